// File: rtl/axi_slave_rw_arbiter.sv
// Burst-level arbiter sharing one single-port slave memory between the AXI write and read data paths.
// Whole bursts are granted round-robin; a watchdog aborts a granted burst that stops making progress.
module axi_slave_rw_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             wr_req,
  input  logic [7:0]       wr_len,
  input  logic             rd_req,
  input  logic [7:0]       rd_len,
  input  logic             wr_beat,
  input  logic             rd_beat,
  output logic             wr_gnt,
  output logic             rd_gnt,
  output logic             burst_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] wr_burst_cnt,
  output logic [CNT_W-1:0] rd_burst_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_t;

  // The watchdog only ever holds 0 .. TIMEOUT_CYCLES-1 before it fires.
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

  state_t           r_state;
  dir_t             r_last_grant;
  logic [8:0]       r_beat_cnt;
  logic [WD_W-1:0]  r_wdog;
  logic             r_wr_gnt;
  logic             r_rd_gnt;
  logic             r_burst_done;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_wr_burst_cnt;
  logic [CNT_W-1:0] r_rd_burst_cnt;

  state_t           w_state_nxt;
  dir_t             w_last_grant_nxt;
  logic [8:0]       w_beat_cnt_nxt;
  logic [WD_W-1:0]  w_wdog_nxt;
  logic             w_done_nxt;
  logic             w_timeout_nxt;
  logic             w_wr_inc;
  logic             w_rd_inc;
  logic             w_beat;

  // Only the beat strobe of the direction that owns the memory counts as progress.
  assign w_beat = (r_state == WR_BURST) ? wr_beat :
                  (r_state == RD_BURST) ? rd_beat : 1'b0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_wdog_nxt       = r_wdog;
    w_done_nxt       = 1'b0;
    w_timeout_nxt    = 1'b0;
    w_wr_inc         = 1'b0;
    w_rd_inc         = 1'b0;

    case (r_state)
      IDLE: begin
        w_wdog_nxt = '0;
        // On a tie the write side wins only if read was granted last.
        if (wr_req && (!rd_req || r_last_grant == DIR_RD)) begin
          w_state_nxt      = WR_BURST;
          w_last_grant_nxt = DIR_WR;
          w_beat_cnt_nxt   = {1'b0, wr_len} + 9'd1;
        end else if (rd_req) begin
          w_state_nxt      = RD_BURST;
          w_last_grant_nxt = DIR_RD;
          w_beat_cnt_nxt   = {1'b0, rd_len} + 9'd1;
        end
      end

      WR_BURST, RD_BURST: begin
        if (w_beat) begin
          w_wdog_nxt = '0;
          if (r_beat_cnt == 9'd1) begin
            w_state_nxt    = IDLE;
            w_beat_cnt_nxt = '0;
            w_done_nxt     = 1'b1;
            w_wr_inc       = (r_state == WR_BURST);
            w_rd_inc       = (r_state == RD_BURST);
          end else begin
            w_beat_cnt_nxt = r_beat_cnt - 9'd1;
          end
        end else if (WD_EN && r_wdog == WD_LIMIT) begin
          // Abort: last_grant keeps the stalled direction so the other side wins the next tie.
          w_state_nxt    = IDLE;
          w_beat_cnt_nxt = '0;
          w_wdog_nxt     = '0;
          w_timeout_nxt  = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end

      default: begin
        w_state_nxt    = IDLE;
        w_beat_cnt_nxt = '0;
        w_wdog_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= IDLE;
      r_last_grant  <= DIR_RD;
      r_beat_cnt    <= '0;
      r_wdog        <= '0;
      r_wr_gnt      <= 1'b0;
      r_rd_gnt      <= 1'b0;
      r_burst_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_beat_cnt    <= w_beat_cnt_nxt;
      r_wdog        <= w_wdog_nxt;
      r_wr_gnt      <= (w_state_nxt == WR_BURST);
      r_rd_gnt      <= (w_state_nxt == RD_BURST);
      r_burst_done  <= w_done_nxt;
      r_timeout_err <= w_timeout_nxt;
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_burst_cnt <= '0;
      r_rd_burst_cnt <= '0;
    end else begin
      if (w_wr_inc && r_wr_burst_cnt != '1) r_wr_burst_cnt <= r_wr_burst_cnt + CNT_W'(1);
      if (w_rd_inc && r_rd_burst_cnt != '1) r_rd_burst_cnt <= r_rd_burst_cnt + CNT_W'(1);
    end
  end

  assign wr_gnt       = r_wr_gnt;
  assign rd_gnt       = r_rd_gnt;
  assign burst_done   = r_burst_done;
  assign timeout_err  = r_timeout_err;
  assign wr_burst_cnt = r_wr_burst_cnt;
  assign rd_burst_cnt = r_rd_burst_cnt;

endmodule

// File: tb/tb_axi_slave_rw_arbiter.sv
// Self-checking bench for axi_slave_rw_arbiter: a per-cycle vector table plus hand-written
// sequences for long bursts, watchdog abort/near-miss and asynchronous reset.
module tb_axi_slave_rw_arbiter;

  localparam int unsigned TO    = 8;
  localparam int unsigned CNT_W = 2;

  logic             ACLK = 1'b0;
  logic             ARESETN;
  logic             wr_req, rd_req, wr_beat, rd_beat;
  logic [7:0]       wr_len, rd_len;
  logic             wr_gnt, rd_gnt, burst_done, timeout_err;
  logic [CNT_W-1:0] wr_burst_cnt, rd_burst_cnt;

  int n_checks = 0;
  int n_errors = 0;

  axi_slave_rw_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .wr_req       (wr_req),
    .wr_len       (wr_len),
    .rd_req       (rd_req),
    .rd_len       (rd_len),
    .wr_beat      (wr_beat),
    .rd_beat      (rd_beat),
    .wr_gnt       (wr_gnt),
    .rd_gnt       (rd_gnt),
    .burst_done   (burst_done),
    .timeout_err  (timeout_err),
    .wr_burst_cnt (wr_burst_cnt),
    .rd_burst_cnt (rd_burst_cnt)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       rst_before;
    logic       wr_req;
    logic [7:0] wr_len;
    logic       rd_req;
    logic [7:0] rd_len;
    logic       wr_beat;
    logic       rd_beat;
    logic       e_wr_gnt;
    logic       e_rd_gnt;
    logic       e_done;
    logic       e_to;
    logic [1:0] e_wcnt;
    logic [1:0] e_rcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Grants must be mutually exclusive in every cycle.
  always @(negedge ACLK) begin
    if (ARESETN === 1'b1) check("gnt_exclusive", {31'd0, wr_gnt & rd_gnt}, 32'd0);
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req = 1'b0; rd_req = 1'b0; wr_beat = 1'b0; rd_beat = 1'b0;
    wr_len = 8'd0; rd_len = 8'd0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    idle_inputs();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
  endtask

  function automatic vec_t mk(input logic rst, input logic wq, input logic [7:0] wl,
                              input logic rq, input logic [7:0] rl, input logic wb,
                              input logic rb, input logic ewg, input logic erg,
                              input logic ed, input logic eto, input logic [1:0] ewc,
                              input logic [1:0] erc);
    vec_t v;
    v.rst_before = rst; v.wr_req = wq; v.wr_len = wl; v.rd_req = rq; v.rd_len = rl;
    v.wr_beat = wb; v.rd_beat = rb; v.e_wr_gnt = ewg; v.e_rd_gnt = erg;
    v.e_done = ed; v.e_to = eto; v.e_wcnt = ewc; v.e_rcnt = erc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int bad;
    idle_inputs();
    ARESETN = 1'b0;
    #12;
    check("reset_wr_gnt", {31'd0, wr_gnt}, 32'd0);
    check("reset_rd_gnt", {31'd0, rd_gnt}, 32'd0);
    check("reset_done", {31'd0, burst_done}, 32'd0);
    check("reset_timeout", {31'd0, timeout_err}, 32'd0);
    check("reset_wcnt", {30'd0, wr_burst_cnt}, 32'd0);
    check("reset_rcnt", {30'd0, rd_burst_cnt}, 32'd0);

    // Write burst of 4 beats, then W/R/W/R round-robin with single-beat bursts.
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 2, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2));

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      wr_req = vecs[i].wr_req; wr_len = vecs[i].wr_len;
      rd_req = vecs[i].rd_req; rd_len = vecs[i].rd_len;
      wr_beat = vecs[i].wr_beat; rd_beat = vecs[i].rd_beat;
      step();
      check($sformatf("vec%0d_wr_gnt", i), {31'd0, wr_gnt}, {31'd0, vecs[i].e_wr_gnt});
      check($sformatf("vec%0d_rd_gnt", i), {31'd0, rd_gnt}, {31'd0, vecs[i].e_rd_gnt});
      check($sformatf("vec%0d_done", i), {31'd0, burst_done}, {31'd0, vecs[i].e_done});
      check($sformatf("vec%0d_timeout", i), {31'd0, timeout_err}, {31'd0, vecs[i].e_to});
      check($sformatf("vec%0d_wcnt", i), {30'd0, wr_burst_cnt}, {30'd0, vecs[i].e_wcnt});
      check($sformatf("vec%0d_rcnt", i), {30'd0, rd_burst_cnt}, {30'd0, vecs[i].e_rcnt});
    end

    // 256-beat read burst with random gaps between beats.
    do_reset();
    rd_req = 1'b1; rd_len = 8'd255;
    step();
    check("long_rd_gnt_start", {31'd0, rd_gnt}, 32'd1);
    rd_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      rd_beat = 1'b0;
      repeat (gap) begin
        step();
        if (!rd_gnt || burst_done || timeout_err) bad++;
      end
      rd_beat = 1'b1;
      step();
      if (i < 255 && (!rd_gnt || burst_done)) bad++;
    end
    rd_beat = 1'b0;
    check("long_rd_midburst_bad_cycles", bad, 0);
    check("long_rd_gnt_end", {31'd0, rd_gnt}, 32'd0);
    check("long_rd_done", {31'd0, burst_done}, 32'd1);
    check("long_rd_rcnt", {30'd0, rd_burst_cnt}, 32'd1);
    step();
    check("long_rd_done_pulse", {31'd0, burst_done}, 32'd0);

    // Watchdog abort: one beat then silence; next tie goes to read.
    do_reset();
    wr_req = 1'b1; wr_len = 8'd1;
    step();
    check("to_wr_gnt", {31'd0, wr_gnt}, 32'd1);
    wr_req = 1'b0; wr_beat = 1'b1;
    step();
    wr_beat = 1'b0;
    bad = 0;
    for (int i = 1; i < int'(TO); i++) begin
      step();
      if (!wr_gnt || timeout_err) bad++;
    end
    check("to_before_limit_bad", bad, 0);
    step();
    check("to_timeout_err", {31'd0, timeout_err}, 32'd1);
    check("to_wr_gnt_drop", {31'd0, wr_gnt}, 32'd0);
    check("to_wcnt", {30'd0, wr_burst_cnt}, 32'd0);
    check("to_no_done", {31'd0, burst_done}, 32'd0);
    wr_req = 1'b1; rd_req = 1'b1;
    step();
    check("to_tie_rd_gnt", {31'd0, rd_gnt}, 32'd1);
    check("to_tie_wr_gnt", {31'd0, wr_gnt}, 32'd0);
    check("to_timeout_pulse", {31'd0, timeout_err}, 32'd0);

    // Foreign read strobes ignored; beats landing on the watchdog limit keep the burst alive.
    do_reset();
    wr_req = 1'b1; wr_len = 8'd1;
    step();
    wr_req = 1'b0;
    bad = 0;
    for (int seg = 0; seg < 2; seg++) begin
      for (int k = 0; k < int'(TO) - 1; k++) begin
        rd_beat = k[0];
        step();
        if (!wr_gnt || rd_gnt || timeout_err || burst_done) bad++;
      end
      rd_beat = 1'b0;
      wr_beat = 1'b1;
      step();
      wr_beat = 1'b0;
      if (seg == 0) check("edge_mid_wr_gnt", {31'd0, wr_gnt}, 32'd1);
    end
    check("edge_stall_bad", bad, 0);
    check("edge_no_timeout", {31'd0, timeout_err}, 32'd0);
    check("edge_done", {31'd0, burst_done}, 32'd1);
    check("edge_wr_gnt_end", {31'd0, wr_gnt}, 32'd0);
    check("edge_wcnt", {30'd0, wr_burst_cnt}, 32'd1);
    check("edge_rcnt", {30'd0, rd_burst_cnt}, 32'd0);

    // Saturation of a 2-bit counter, then asynchronous reset mid-burst.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      rd_req = 1'b1; rd_len = 8'd0;
      step();
      rd_req = 1'b0; rd_beat = 1'b1;
      step();
      rd_beat = 1'b0;
      if (b == 2) check("sat_rcnt_3", {30'd0, rd_burst_cnt}, 32'd3);
    end
    check("sat_rcnt_hold", {30'd0, rd_burst_cnt}, 32'd3);
    step();
    rd_req = 1'b1; rd_len = 8'd3;
    step();
    rd_req = 1'b0; rd_beat = 1'b1;
    step();
    rd_beat = 1'b0;
    check("arst_rd_gnt_before", {31'd0, rd_gnt}, 32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("arst_rd_gnt_drop", {31'd0, rd_gnt}, 32'd0);
    check("arst_rcnt", {30'd0, rd_burst_cnt}, 32'd0);
    step();
    ARESETN = 1'b1;
    step();
    check("arst_forgotten", {31'd0, rd_gnt | wr_gnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
